// File: rtl/spi_frame_ctrl_if.sv
// SPI word-engine and register-file signal bundle for spi_frame_ctrl.
// master: the frame controller side; slave: the SPI slave / register file side.
interface spi_frame_ctrl_if #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_W    = 7
);
    logic                 cs;
    logic                 rx_valid;
    logic [DATA_SIZE-1:0] rx_data;
    logic [DATA_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [ADDR_W-1:0]    reg_addr;
    logic [DATA_SIZE-1:0] reg_wdata;
    logic                 reg_we;
    logic                 reg_re;
    logic [DATA_SIZE-1:0] reg_rdata;
    logic                 busy;
    logic                 err;

    modport master (
        input  cs, rx_valid, rx_data, tx_ready, reg_rdata,
        output tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, busy, err
    );

    modport slave (
        output cs, rx_valid, rx_data, tx_ready, reg_rdata,
        input  tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, busy, err
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// Frames the 16-bit SPI word stream into register-file reads/writes (header + data words).
// Optional SPI_FRAME_CRC_EN: trailing CRC-16/CCITT word, writes buffered and committed on CRC match.
module spi_frame_ctrl #(
    parameter int DATA_SIZE   = 16,
    parameter int ADDR_W      = 7,
    parameter int LEN_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    spi_frame_ctrl_if.master bus
);
    localparam int                   CNT_W     = LEN_W + 1;
    localparam logic [DATA_SIZE-1:0] IDLE_WORD = DATA_SIZE'(16'h5555);

    typedef enum logic [3:0] {
        IDLE, HDR, WR_DATA, RD_FETCH, RD_LOAD, RD_WAIT
`ifdef SPI_FRAME_CRC_EN
        , WR_CRC, WR_FLUSH, RD_CRC
`endif
    } state_t;

    state_t               state, state_n;
    logic [ADDR_W-1:0]    addr, addr_n;
    logic [CNT_W-1:0]     count, count_n;
    logic [1:0]           ph, ph_n;
    logic                 err_q, err_n;
    logic                 reg_we_q, reg_we_n;
    logic                 reg_re_q, reg_re_n;
    logic [ADDR_W-1:0]    reg_addr_q, reg_addr_n;
    logic [DATA_SIZE-1:0] tx_data_q, tx_data_n;
    logic                 tx_valid_q, tx_valid_n;
    logic [DATA_SIZE-1:0] rx_word;

    logic [SYNC_STAGES-1:0] cs_sync, rxv_sync, txr_sync;
    logic                   cs_s, rxv_s, txr_s;
    logic                   cs_q, rxv_q, txr_q;
    logic                   cs_rise, rx_stb;
    logic [15:0]            tx_words;

    logic                 hdr_w;
    logic [ADDR_W-1:0]    hdr_addr;
    logic [LEN_W-1:0]     hdr_len;

    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign rxv_s   = rxv_sync[SYNC_STAGES-1];
    assign txr_s   = txr_sync[SYNC_STAGES-1];
    assign cs_rise = cs_s & ~cs_q;
    assign rx_stb  = rxv_s & ~rxv_q;

    assign hdr_w    = bus.rx_data[DATA_SIZE-1];
    assign hdr_addr = bus.rx_data[LEN_W +: ADDR_W];
    assign hdr_len  = bus.rx_data[LEN_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync  <= '1;
            rxv_sync <= '0;
            txr_sync <= '0;
            cs_q     <= 1'b1;
            rxv_q    <= 1'b0;
            txr_q    <= 1'b0;
            tx_words <= '0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            rxv_sync <= {rxv_sync[SYNC_STAGES-2:0], bus.rx_valid};
            txr_sync <= {txr_sync[SYNC_STAGES-2:0], bus.tx_ready};
            cs_q     <= cs_s;
            rxv_q    <= rxv_s;
            txr_q    <= txr_s;
            if (txr_s && !txr_q)
                tx_words <= tx_words + 16'd1;
        end
    end

`ifdef SPI_FRAME_CRC_EN
    logic [15:0]          crc, crc_n;
    logic                 drop, drop_n;
    logic [2:0]           wcnt, wcnt_n;
    logic [1:0]           rptr, rptr_n;
    logic [DATA_SIZE-1:0] wdata_q, wdata_n;
    logic [DATA_SIZE-1:0] fifo [4];
    logic                 fifo_push;

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [DATA_SIZE-1:0] d);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < DATA_SIZE; i++)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[DATA_SIZE-1-i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            crc     <= 16'hFFFF;
            drop    <= 1'b0;
            wcnt    <= '0;
            rptr    <= '0;
            wdata_q <= '0;
        end else begin
            crc     <= crc_n;
            drop    <= drop_n;
            wcnt    <= wcnt_n;
            rptr    <= rptr_n;
            wdata_q <= wdata_n;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo[wcnt[1:0]] <= bus.rx_data;
    end

    assign bus.reg_wdata = wdata_q;
`else
    assign bus.reg_wdata = rx_word;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            count      <= '0;
            ph         <= '0;
            err_q      <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            reg_addr_q <= '0;
            tx_data_q  <= IDLE_WORD;
            tx_valid_q <= 1'b0;
            rx_word    <= '0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            count      <= count_n;
            ph         <= ph_n;
            err_q      <= err_n;
            reg_we_q   <= reg_we_n;
            reg_re_q   <= reg_re_n;
            reg_addr_q <= reg_addr_n;
            tx_data_q  <= tx_data_n;
            tx_valid_q <= tx_valid_n;
            if (rx_stb)
                rx_word <= bus.rx_data;
        end
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        count_n    = count;
        ph_n       = ph;
        err_n      = err_q;
        reg_we_n   = 1'b0;
        reg_re_n   = 1'b0;
        reg_addr_n = reg_addr_q;
        tx_data_n  = tx_data_q;
        tx_valid_n = 1'b0;
`ifdef SPI_FRAME_CRC_EN
        crc_n     = crc;
        drop_n    = drop;
        wcnt_n    = wcnt;
        rptr_n    = rptr;
        wdata_n   = wdata_q;
        fifo_push = 1'b0;
`endif
        // A cs deassert aborts whatever is in flight, including an rx_stb in the same cycle.
        if (cs_rise && state != IDLE) begin
            state_n = IDLE;
            ph_n    = '0;
            if ((state == WR_DATA || state == RD_WAIT) && count != '0)
                err_n = 1'b1;
`ifdef SPI_FRAME_CRC_EN
            if (state == WR_CRC || state == RD_CRC)
                err_n = 1'b1;
`endif
        end else begin
            if (rx_stb && (state == RD_FETCH || state == RD_LOAD)) begin
                err_n = 1'b1;
                if (count != '0)
                    count_n = count - CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (!cs_s)
                        state_n = HDR;
                end
                HDR: begin
                    if (rx_stb) begin
                        addr_n  = hdr_addr;
                        count_n = CNT_W'(hdr_len) + CNT_W'(1);
                        err_n   = 1'b0;
                        state_n = hdr_w ? WR_DATA : RD_FETCH;
`ifdef SPI_FRAME_CRC_EN
                        crc_n  = crc16(16'hFFFF, bus.rx_data);
                        wcnt_n = '0;
                        drop_n = hdr_w && (hdr_len > LEN_W'(3));
                        if (hdr_w && (hdr_len > LEN_W'(3)))
                            err_n = 1'b1;
`endif
                    end
                end
                WR_DATA: begin
                    if (rx_stb) begin
                        count_n = count - CNT_W'(1);
`ifdef SPI_FRAME_CRC_EN
                        crc_n = crc16(crc, bus.rx_data);
                        if (!drop) begin
                            fifo_push = 1'b1;
                            wcnt_n    = wcnt + 3'd1;
                        end
                        if (count == CNT_W'(1))
                            state_n = WR_CRC;
`else
                        reg_we_n   = 1'b1;
                        reg_addr_n = addr;
                        addr_n     = addr + ADDR_W'(1);
                        if (count == CNT_W'(1))
                            state_n = HDR;
`endif
                    end
                end
                RD_FETCH: begin
                    reg_re_n   = 1'b1;
                    reg_addr_n = addr;
                    addr_n     = addr + ADDR_W'(1);
                    ph_n       = '0;
                    state_n    = RD_LOAD;
                end
                // ph0: read in flight; ph1: capture rdata; ph1/ph2 hold tx_valid for two clocks.
                RD_LOAD: begin
                    ph_n = ph + 2'd1;
                    case (ph)
                        2'd1: begin
                            tx_data_n  = bus.reg_rdata;
                            tx_valid_n = 1'b1;
                        end
                        2'd2: tx_valid_n = 1'b1;
                        2'd3: state_n = RD_WAIT;
                        default: ;
                    endcase
                end
                RD_WAIT: begin
                    if (rx_stb) begin
                        if (count != '0)
                            count_n = count - CNT_W'(1);
`ifdef SPI_FRAME_CRC_EN
                        crc_n = crc16(crc, bus.rx_data);
`endif
                        if (count <= CNT_W'(1)) begin
                            tx_data_n  = IDLE_WORD;
                            tx_valid_n = 1'b1;
`ifdef SPI_FRAME_CRC_EN
                            state_n = RD_CRC;
`else
                            state_n = HDR;
`endif
                        end else begin
                            state_n = RD_FETCH;
                        end
                    end
                end
`ifdef SPI_FRAME_CRC_EN
                WR_CRC: begin
                    if (rx_stb) begin
                        rptr_n = '0;
                        if (!drop && bus.rx_data == crc) begin
                            state_n = WR_FLUSH;
                        end else begin
                            err_n   = 1'b1;
                            state_n = HDR;
                        end
                    end
                end
                WR_FLUSH: begin
                    reg_we_n   = 1'b1;
                    reg_addr_n = addr;
                    wdata_n    = fifo[rptr];
                    addr_n     = addr + ADDR_W'(1);
                    rptr_n     = rptr + 2'd1;
                    if (3'(rptr) + 3'd1 == wcnt)
                        state_n = HDR;
                end
                RD_CRC: begin
                    if (rx_stb) begin
                        if (bus.rx_data != crc)
                            err_n = 1'b1;
                        state_n = HDR;
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.reg_addr = reg_addr_q;
    assign bus.reg_we   = reg_we_q;
    assign bus.reg_re   = reg_re_q;
    assign bus.busy     = (state != IDLE);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: frame table with scoreboard queues for writes, reads and tx loads,
// plus hand sequences for cs abort and reset during a read.
module tb_spi_frame_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_frame_ctrl_if #(.DATA_SIZE(16), .ADDR_W(7)) bus ();

    spi_frame_ctrl #(
        .DATA_SIZE(16),
        .ADDR_W(7),
        .LEN_W(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Register file stub: synchronous write, read data one clock after reg_re.
    logic [15:0] mem [128];
    always @(posedge clk) begin
        if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
        if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
    end

    typedef struct { logic [6:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [15:0] data; int unsigned width; } tx_t;
    typedef struct {
        logic [15:0]      hdr;
        int unsigned      n;
        logic [1:0][6:0]  a;
        logic [1:0][15:0] d;
    } frame_t;

    wr_t         wr_q[$];
    logic [6:0]  re_q[$];
    tx_t         tx_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        txv_prev = 1'b0;
    int unsigned run = 0;
    int unsigned cur_w = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        tx_t t;
        if (bus.reg_we) begin
            check("reg_we_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                check("we_addr", 32'(bus.reg_addr), 32'(e.addr));
                check("we_data", 32'(bus.reg_wdata), 32'(e.data));
            end
        end
        if (bus.reg_re) begin
            check("reg_re_expected", 32'(re_q.size() != 0), 32'd1);
            if (re_q.size() != 0)
                check("re_addr", 32'(bus.reg_addr), 32'(re_q.pop_front()));
        end
        if (bus.tx_valid && !txv_prev) begin
            check("tx_load_expected", 32'(tx_q.size() != 0), 32'd1);
            if (tx_q.size() != 0) begin
                t = tx_q.pop_front();
                cur_w = t.width;
                check("tx_data", 32'(bus.tx_data), 32'(t.data));
            end
            run = 1;
        end else if (bus.tx_valid) begin
            run++;
        end else if (txv_prev) begin
            check("tx_valid_width", run, cur_w);
        end
        txv_prev = bus.tx_valid;
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            monitor();
        end
    endtask

    task automatic send_word(input logic [15:0] w, input int unsigned gap = 20);
        bus.rx_data = w;
        tick(2);
        bus.rx_valid = 1'b1;
        bus.tx_ready = 1'b1;
        tick(4);
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        tick(gap);
    endtask

    function automatic frame_t mk(input logic [15:0] hdr, input int unsigned n,
                                  input logic [6:0] a0, input logic [6:0] a1,
                                  input logic [15:0] d0, input logic [15:0] d1);
        frame_t f;
        f.hdr  = hdr;
        f.n    = n;
        f.a[0] = a0;
        f.a[1] = a1;
        f.d[0] = d0;
        f.d[1] = d1;
        return f;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        frame_t frames [8];
        frame_t f;
        logic   is_w;
        logic   got_re;

        // Writes and reads for d[] give the data expected on reg_wdata / tx_data.
        frames[0] = mk(16'h8A01, 2, 7'h0A, 7'h0B, 16'h1234, 16'hBEEF);
        frames[1] = mk(16'hFF01, 2, 7'h7F, 7'h00, 16'h1111, 16'h2222);
        frames[2] = mk(16'h8500, 1, 7'h05, 7'h00, 16'hCAFE, 16'h0000);
        frames[3] = mk(16'h0500, 1, 7'h05, 7'h00, 16'hCAFE, 16'h0000);
        frames[4] = mk(16'h0A01, 2, 7'h0A, 7'h0B, 16'h1234, 16'hBEEF);
        frames[5] = mk(16'h7F01, 2, 7'h7F, 7'h00, 16'h1111, 16'h2222);
        frames[6] = mk(16'h8300, 1, 7'h03, 7'h00, 16'h00AA, 16'h0000);
        frames[7] = mk(16'h0300, 1, 7'h03, 7'h00, 16'h00AA, 16'h0000);

        rst          = 1'b1;
        bus.cs       = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 16'h0000;
        bus.tx_ready = 1'b0;
        tick(3);
        check("rst_tx_data", 32'(bus.tx_data), 32'h5555);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_reg_we", 32'(bus.reg_we), 32'd0);
        check("rst_reg_re", 32'(bus.reg_re), 32'd0);
        check("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        check("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        tick(2);
        check("idle_busy", 32'(bus.busy), 32'd0);
        bus.cs = 1'b0;
        tick(6);
        check("hdr_busy", 32'(bus.busy), 32'd1);

        // All table frames run back-to-back under one cs assertion.
        for (int unsigned i = 0; i < 8; i++) begin
            f    = frames[i];
            is_w = f.hdr[15];
            for (int unsigned k = 0; k < f.n; k++) begin
                if (is_w) begin
                    wr_q.push_back('{f.a[k[0]], f.d[k[0]]});
                end else begin
                    re_q.push_back(f.a[k[0]]);
                    tx_q.push_back('{f.d[k[0]], 2});
                end
            end
            if (!is_w) tx_q.push_back('{16'h5555, 1});
            send_word(f.hdr);
            for (int unsigned k = 0; k < f.n; k++)
                send_word(is_w ? f.d[k[0]] : 16'hFFFF);
            check($sformatf("busy_frame%0d", i), 32'(bus.busy), 32'd1);
            check($sformatf("err_frame%0d", i), 32'(bus.err), 32'd0);
            check($sformatf("idle_word_frame%0d", i), 32'(bus.tx_data), 32'h5555);
        end

        // cs abort after 1 of 3 write words.
        wr_q.push_back('{7'h02, 16'h5A5A});
        send_word(16'h8202);
        send_word(16'h5A5A);
        bus.cs = 1'b1;
        tick(8);
        check("abort_err", 32'(bus.err), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        bus.cs = 1'b0;
        tick(6);
        wr_q.push_back('{7'h06, 16'h0102});
        wr_q.push_back('{7'h07, 16'h0304});
        send_word(16'h8601);
        check("hdr_clears_err", 32'(bus.err), 32'd0);
        send_word(16'h0102);
        send_word(16'h0304);
        check("post_abort_busy", 32'(bus.busy), 32'd1);

        // Reset while RD_LOAD is waiting on read data.
        re_q.push_back(7'h05);
        bus.rx_data = 16'h0500;
        tick(1);
        bus.rx_valid = 1'b1;
        got_re = 1'b0;
        for (int unsigned t = 0; t < 50 && !got_re; t++) begin
            tick(1);
            got_re = bus.reg_re;
        end
        check("rd_reg_re_seen", 32'(got_re), 32'd1);
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        tick(1);
        check("rstrd_tx_data", 32'(bus.tx_data), 32'h5555);
        check("rstrd_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rstrd_busy", 32'(bus.busy), 32'd0);
        bus.cs = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(30);
        check("rstrd_idle_busy", 32'(bus.busy), 32'd0);
        check("rstrd_err", 32'(bus.err), 32'd0);

        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("re_q_drained", 32'(re_q.size()), 32'd0);
        check("tx_q_drained", 32'(tx_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
- Protocol controller between the SPI slave word engine and the on-chip register file.
- Turns the raw 16-bit word stream into framed register reads and writes: header word, then data words.
- Sequences write strobes into the register file.
- Loads read-back words into the SPI slave transmit path.
- Only the SPI slave runs off sclk. This block runs entirely in the system clock domain.

Parameters:
- DATA_SIZE, 16, SPI word width; must match the SPI slave.
- ADDR_W, 7, register address width; ADDR_W <= DATA_SIZE-9.
- LEN_W, 8, length field width in the header.
- SYNC_STAGES, 2, synchronizer depth for signals from the sclk domain.

Ports:
- clk  in  1  system clock, FPGA_CLK domain; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  SPI chip select, active low, asynchronous; synchronized internally.
- rx_valid  in  1  SPI slave word-complete level (high at word boundary), sclk domain.
- rx_data  in  DATA_SIZE  received word; stable while rx_valid is high.
- tx_data  out  DATA_SIZE  word for the SPI slave to shift out next.
- tx_valid  out  1  load strobe; the SPI slave latches tx_data on its rising edge.
- tx_ready  in  1  SPI slave "transmit word done" level, sclk domain.
- reg_addr  out  ADDR_W  register file address.
- reg_wdata  out  DATA_SIZE  register write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  DATA_SIZE  read data, valid exactly 1 clk after reg_re.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  sticky frame-error flag; cleared by rst or by the next valid header.

Behaviour:
- Reset values: all outputs 0, except tx_data = 16'h5555 (idle pattern). FSM = IDLE.
- Synchronization:
  - cs, rx_valid and tx_ready each pass through SYNC_STAGES flops.
  - rx_stb = one-clk pulse on the synced rising edge of rx_valid.
  - rx_data is captured into rx_word on the rx_stb cycle, never sampled elsewhere.
- Header format: bit15 = W (1 = write, 0 = read); bits[14:8] = addr; bits[7:0] = len.
  - Word count = len+1, so 1..256 words.
- Address increments by 1 after each data word and wraps modulo 2^ADDR_W.
- FSM states: IDLE, HDR, WR_DATA, RD_FETCH, RD_LOAD, RD_WAIT.
  - IDLE -> HDR when synced cs is low.
  - HDR, on rx_stb:
    - Latch addr and count; clear err.
    - W=1 -> WR_DATA.
    - W=0 -> RD_FETCH.
  - WR_DATA, on rx_stb:
    - reg_we=1, reg_wdata=rx_word, reg_addr=current addr (all in the cycle after rx_stb).
    - Decrement count. count reaching 0 -> HDR (back-to-back frames allowed without cs toggle).
  - RD_FETCH:
    - reg_re=1 for 1 clk -> RD_LOAD.
  - RD_LOAD:
    - tx_data <= reg_rdata; tx_valid high for exactly 2 clks, then low -> RD_WAIT.
  - RD_WAIT, on rx_stb (dummy word clocked by the master):
    - Decrement count.
    - count 0 -> HDR, with tx_data restored to 16'h5555 and pulsed once.
    - Otherwise -> RD_FETCH.
- Read latency: the word for addr A shifts out in the SPI word following the header. The master must leave at least 8 clk of sclk-idle margin per word.
- Synced cs rising edge (deassert) in any state:
  - -> IDLE next clk.
  - If count != 0 in WR_DATA or RD_WAIT, set err.
  - No reg_we is issued for a partial word.
- rx_stb arriving while in RD_FETCH or RD_LOAD: set err; count is still decremented; the sequence continues.
- rst mid-frame: immediate return to reset values; no strobe in the reset cycle.
- rst has priority over cs and rx_stb.
- tx_ready is used only to count transmitted words for the debug feature below; it never gates the FSM.

Optional Feature:
- Macro: SPI_FRAME_CRC_EN.
- Defined:
  - Every frame carries one trailing CRC-16/CCITT word (poly 0x1021, init 0xFFFF) covering the header and data words.
  - Write data is buffered in a 4-entry holding FIFO. Frames with len > 3 set err and are discarded.
  - reg_we is issued only after the CRC matches. A mismatch sets err and drops all writes.
- Not defined: no CRC word, no buffering; writes stream out as described above.

Test Plan:
- Write frame: header 0x8A01 (W, addr 0x0A, 2 words), data 0x1234, 0xBEEF -> reg_we at addr 0x0A/0x1234, then 0x0B/0xBEEF; busy stays high; err=0.
- Read frame: header 0x0500 with reg[0x05]=0xCAFE, one dummy word -> reg_re at addr 5; tx_valid 2-clk pulse with tx_data=0xCAFE; next MISO word = 0xCAFE.
- Wrap: write header 0xFF01 (addr 0x7F, 2 words) -> writes land at 0x7F, then 0x00.
- Abort: cs deasserts after 1 of 3 write data words -> exactly one reg_we; err=1; FSM back in IDLE; next good header clears err.
- Reset mid-read: rst during RD_LOAD -> tx_data=0x5555, tx_valid=0, busy=0 the next clk; no reg_re after reset.
- Back-to-back frames: write header then read header with no cs toggle -> both frames execute, with no idle word needed between them.
